// File: rtl/jtpopeye_dwnld_pkg.sv
// jtpopeye_dwnld_pkg: shared constants, reset FSM states and Popeye PROM indices
package jtpopeye_dwnld_pkg;

    localparam logic [21:0] DEF_PROM_START = 22'h10000;
    localparam logic [21:0] DEF_ENC_ADDR   = 22'h0FFFF;

    localparam logic [1:0] ST_WAIT_RDY = 2'd0;
    localparam logic [1:0] ST_LOAD     = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_RUN      = 2'd3;

    typedef enum logic [2:0] {
        PROM_7J = 3'd0,
        PROM_5B = 3'd1,
        PROM_5A = 3'd2,
        PROM_4A = 3'd3,
        PROM_3A = 3'd4,
        PROM_5N = 3'd5
    } popeye_prom_e;

endpackage

// File: rtl/jtpopeye_dwnld_rstseq.sv
// jtpopeye_dwnld_rstseq: game reset sequencer, holds game_rst until download done and ROM ready
module jtpopeye_dwnld_rstseq
    import jtpopeye_dwnld_pkg::*;
#(
    parameter int RST_HOLD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic dwn_rise,
    input  logic downloading,
    input  logic pending,
    input  logic rom_ready,
    output logic game_rst
);

    localparam int CW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;

    logic [1:0]    state;
    logic [1:0]    nxt;
    logic [CW-1:0] cnt;

    // next state: a new download always restarts the load phase
    always_comb begin
        nxt = dwn_rise ? ST_LOAD :
              state == ST_LOAD     ? (!downloading && !pending ? ST_WAIT_RDY : ST_LOAD) :
              state == ST_WAIT_RDY ? (rom_ready ? ST_HOLD : ST_WAIT_RDY) :
              !rom_ready           ? ST_WAIT_RDY :
              state == ST_HOLD && cnt == '0 ? ST_RUN : state;
    end

    // state register and hold counter, loaded on entry to HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_WAIT_RDY;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= state == ST_WAIT_RDY && nxt == ST_HOLD ? CW'(RST_HOLD - 1) :
                     state == ST_HOLD && cnt != '0         ? cnt - CW'(1) : cnt;
        end
    end

    assign game_rst = state != ST_RUN;

endmodule

// File: rtl/jtpopeye_dwnld.sv
// jtpopeye_dwnld: ioctl download router to SDRAM and PROM regions plus game reset control
// Optional: define JTPOPEYE_CHKSUM_EN to build the 16-bit download checksum.
module jtpopeye_dwnld
    import jtpopeye_dwnld_pkg::*;
#(
    parameter int                ROM_AW     = 22,
    parameter int                PROM_CH    = 6,
    parameter int                PROM_AW    = 11,
    parameter logic [ROM_AW-1:0] PROM_START = ROM_AW'(DEF_PROM_START),
    parameter logic [ROM_AW-1:0] ENC_ADDR   = ROM_AW'(DEF_ENC_ADDR),
    parameter int                RST_HOLD   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               downloading,
    input  logic [ROM_AW-1:0]  ioctl_addr,
    input  logic [7:0]         ioctl_data,
    input  logic               ioctl_wr,
    output logic [ROM_AW-2:0]  prog_addr,
    output logic [15:0]        prog_data,
    output logic [1:0]         prog_mask,
    output logic               prog_we,
    input  logic               prog_ack,
    output logic [PROM_AW-1:0] prom_addr,
    output logic [7:0]         prom_data,
    output logic [PROM_CH-1:0] prom_we,
    output logic               encrypted,
    input  logic               rom_ready,
    output logic               game_rst,
    output logic               dwn_err,
    output logic [15:0]        checksum
);

    localparam logic [ROM_AW:0] PROM_LEN = (ROM_AW + 1)'(PROM_CH) << PROM_AW;

    logic              dwn_l;
    logic              dwn_rise;
    logic              wr;
    logic              in_sdram;
    logic              in_prom;
    logic              sd_acc;
    logic              drop;
    logic [ROM_AW-1:0] prom_off;

    // address decode and SDRAM slot arbitration
    always_comb begin
        dwn_rise = downloading & ~dwn_l;
        wr       = ioctl_wr & downloading;
        prom_off = ioctl_addr - PROM_START;
        in_sdram = ioctl_addr < PROM_START;
        in_prom  = !in_sdram && {1'b0, prom_off} < PROM_LEN;
        sd_acc   = wr & in_sdram & (~prog_we | prog_ack);
        drop     = wr & in_sdram & prog_we & ~prog_ack;
    end

    // single pending SDRAM slot; an ack frees it unless a new byte refills it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwn_l     <= 1'b0;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= '0;
            dwn_err   <= 1'b0;
        end else begin
            dwn_l   <= downloading;
            prog_we <= sd_acc | (prog_we & ~prog_ack);
            dwn_err <= drop | (dwn_err & ~dwn_rise);
            if (sd_acc) begin
                prog_addr <= ioctl_addr[ROM_AW-1:1];
                prog_data <= {ioctl_data, ioctl_data};
                prog_mask <= ioctl_addr[0] ? 2'b01 : 2'b10;
            end
        end
    end

    // one-cycle PROM strobe for the region the address falls in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prom_we   <= '0;
            prom_addr <= '0;
            prom_data <= '0;
        end else begin
            prom_we <= wr && in_prom ? PROM_CH'(1) << prom_off[ROM_AW-1:PROM_AW] : '0;
            if (wr && in_prom) begin
                prom_addr <= prom_off[PROM_AW-1:0];
                prom_data <= ioctl_data;
            end
        end
    end

    // encryption flag taken from bit 0 of the byte at ENC_ADDR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) encrypted <= 1'b0;
        else if (wr && ioctl_addr == ENC_ADDR) encrypted <= ioctl_data[0];
    end

`ifdef JTPOPEYE_CHKSUM_EN
    logic acc;

    assign acc = sd_acc | (wr & in_prom);

    // running sum of accepted bytes, restarted with every download
    always_ff @(posedge clk or posedge rst) begin
        if (rst) checksum <= '0;
        else checksum <= (dwn_rise ? 16'd0 : checksum) + (acc ? {8'd0, ioctl_data} : 16'd0);
    end
`else
    assign checksum = '0;
`endif

    jtpopeye_dwnld_rstseq #(
        .RST_HOLD(RST_HOLD)
    ) u_rstseq (
        .clk        (clk),
        .rst        (rst),
        .dwn_rise   (dwn_rise),
        .downloading(downloading),
        .pending    (prog_we),
        .rom_ready  (rom_ready),
        .game_rst   (game_rst)
    );

endmodule

// File: tb/tb_jtpopeye_dwnld.sv
// tb_jtpopeye_dwnld: directed self-checking bench with a PROM write scoreboard
module tb_jtpopeye_dwnld;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic        prog_ack = 1'b0;
    logic        rom_ready = 1'b0;
    logic [21:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic [20:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic [10:0] prom_addr;
    logic [7:0]  prom_data;
    logic [5:0]  prom_we;
    logic        encrypted;
    logic        game_rst;
    logic        dwn_err;
    logic [15:0] checksum;

    int          checks = 0;
    int          errors = 0;
    logic [24:0] prom_q[$];
    logic [15:0] exp_sum = '0;

    always #5 clk = ~clk;

    jtpopeye_dwnld dut (
        .clk        (clk),
        .rst        (rst),
        .downloading(downloading),
        .ioctl_addr (ioctl_addr),
        .ioctl_data (ioctl_data),
        .ioctl_wr   (ioctl_wr),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_mask  (prog_mask),
        .prog_we    (prog_we),
        .prog_ack   (prog_ack),
        .prom_addr  (prom_addr),
        .prom_data  (prom_data),
        .prom_we    (prom_we),
        .encrypted  (encrypted),
        .rom_ready  (rom_ready),
        .game_rst   (game_rst),
        .dwn_err    (dwn_err),
        .checksum   (checksum)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(logic [21:0] a, logic [7:0] d, logic acc);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr = 1'b0;
        if (acc) exp_sum += {8'd0, d};
    endtask

    task automatic push_prom(int r, int off, logic [7:0] d);
        prom_q.push_back({6'(1 << r), 11'(off), d});
    endtask

    task automatic ack();
        prog_ack = 1'b1;
        step();
        prog_ack = 1'b0;
    endtask

    function automatic logic [15:0] sum_exp();
`ifdef JTPOPEYE_CHKSUM_EN
        return exp_sum;
`else
        return 16'd0;
`endif
    endfunction

    // PROM scoreboard: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && prom_we !== 6'd0) begin
            if (prom_q.size() == 0) chk("prom_unexpected", {7'd0, prom_we, prom_addr, prom_data}, 32'd0);
            else chk("prom_write", {7'd0, prom_we, prom_addr, prom_data}, {7'd0, prom_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        chk("rst_game_rst", game_rst, 1);
        chk("rst_prog_we", prog_we, 0);
        chk("rst_prom_we", prom_we, 0);
        chk("rst_encrypted", encrypted, 0);
        chk("rst_dwn_err", dwn_err, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_prog_addr", prog_addr, 0);
        rst = 1'b0;
        step();
        downloading = 1'b1;
        exp_sum = '0;
        step();
        wr_byte(22'h0003, 8'hA5, 1);
        chk("sd_prog_we", prog_we, 1);
        chk("sd_prog_addr", prog_addr, 21'h1);
        chk("sd_prog_data", prog_data, 16'hA5A5);
        chk("sd_prog_mask", prog_mask, 2'b01);
        chk("dl_game_rst", game_rst, 1);
        step();
        step();
        chk("sd_held", prog_we, 1);
        ack();
        chk("sd_acked", prog_we, 0);
        push_prom(1, 7, 8'h11);
        push_prom(5, 0, 8'h22);
        wr_byte(22'h10807, 8'h11, 1);
        chk("prom1_no_prog_we", prog_we, 0);
        wr_byte(22'h12800, 8'h22, 1);
        chk("prom2_no_prog_we", prog_we, 0);
        wr_byte(22'h13000, 8'h99, 0);
        chk("ignored_prog_we", prog_we, 0);
        chk("ignored_prom_we", prom_we, 0);
        wr_byte(22'h0FFFF, 8'h01, 1);
        chk("enc_set", encrypted, 1);
        chk("enc_prog_mask", prog_mask, 2'b01);
        ack();
        wr_byte(22'h0010, 8'h33, 1);
        chk("ovr_first_we", prog_we, 1);
        wr_byte(22'h0011, 8'h44, 0);
        chk("ovr_err", dwn_err, 1);
        chk("ovr_drop_addr", prog_addr, 21'h8);
        chk("ovr_drop_data", prog_data, 16'h3333);
        chk("ovr_drop_mask", prog_mask, 2'b10);
        prog_ack = 1'b1;
        wr_byte(22'h0020, 8'h55, 1);
        prog_ack = 1'b0;
        chk("same_cycle_we", prog_we, 1);
        chk("same_cycle_addr", prog_addr, 21'h10);
        chk("same_cycle_data", prog_data, 16'h5555);
        chk("same_cycle_err", dwn_err, 1);
        ack();
        chk("same_cycle_acked", prog_we, 0);
        chk("sum_dl1", checksum, sum_exp());
        downloading = 1'b0;
        step();
        step();
        chk("wait_game_rst", game_rst, 1);
        rom_ready = 1'b1;
        for (int i = 0; i < 16; i++) step();
        chk("hold_last", game_rst, 1);
        step();
        chk("released", game_rst, 0);
        chk("err_sticky", dwn_err, 1);
        rom_ready = 1'b0;
        step();
        chk("run_drop_ready", game_rst, 1);
        downloading = 1'b1;
        exp_sum = '0;
        step();
        chk("err_cleared", dwn_err, 0);
        wr_byte(22'h0FFFF, 8'h00, 1);
        chk("enc_clear", encrypted, 0);
        ack();
        for (int i = 0; i < 300; i++) begin
            push_prom(0, i, 8'hFF);
            wr_byte(22'h10000 + 22'(i), 8'hFF, 1);
        end
        chk("sum_dl2", checksum, sum_exp());
        step();
        step();
        chk("prom_q_drained", prom_q.size(), 0);
        wr_byte(22'h0FFFF, 8'h01, 1);
        chk("enc_before_rst", encrypted, 1);
        chk("we_before_rst", prog_we, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_prog_we", prog_we, 0);
        chk("async_encrypted", encrypted, 0);
        chk("async_checksum", checksum, 0);
        chk("async_game_rst", game_rst, 1);
        chk("async_prog_addr", prog_addr, 0);
        chk("async_prog_mask", prog_mask, 0);
        chk("async_prom_addr", prom_addr, 0);
        chk("async_dwn_err", dwn_err, 0);
        step();
        rst = 1'b0;
        downloading = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtpopeye_dwnld.md
# jtpopeye_dwnld

Parametrised download router and reset sequencer for the Popeye core. It sits between the ioctl download port and the SDRAM programming interface and the video PROM write strobes, with N PROM regions instead of a fixed six. It tracks the SDRAM write handshake, detects overruns, and latches the encryption flag. It also owns the game reset: `game_rst` stays high until the download is complete and the ROM reports ready.

## Interface
Parameters:
- ROM_AW, 22: ioctl byte-address width.
- PROM_CH, 6: number of PROM regions; one `prom_we` bit each.
- PROM_AW, 11: per-region PROM address width. Each region is 2**PROM_AW bytes.
- PROM_START, 22'h10000: byte address of region 0; regions are contiguous.
- ENC_ADDR, 22'h0FFFF: byte address whose bit 0 sets `encrypted`.
- RST_HOLD, 16: number of cycles `game_rst` stays high after `rom_ready`.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- downloading, in, 1: download in progress.
- ioctl_addr, in, ROM_AW: byte address.
- ioctl_data, in, 8: byte data.
- ioctl_wr, in, 1: one-cycle write strobe.
- prog_addr, out, ROM_AW-1: SDRAM word address, equal to ioctl_addr>>1.
- prog_data, out, 16: the byte duplicated in both halves.
- prog_mask, out, 2: active-low byte mask.
- prog_we, out, 1: SDRAM write request.
- prog_ack, in, 1: SDRAM accepted the request.
- prom_addr, out, PROM_AW: offset inside the region.
- prom_data, out, 8: PROM byte.
- prom_we, out, PROM_CH: one-hot, one-cycle PROM write strobe.
- encrypted, out, 1: latched encryption flag.
- rom_ready, in, 1: ROM controller ready.
- game_rst, out, 1: reset to the CPU and video.
- dwn_err, out, 1: sticky write-overrun flag.
- checksum, out, 16: download checksum.

## Operation
Routing, applied on a sampled `ioctl_wr` while `downloading` is high:
- addr < PROM_START: SDRAM write. `prog_mask` = addr[0] ? 2'b01 : 2'b10.
- PROM_START ≤ addr < PROM_START + PROM_CH·2**PROM_AW: PROM write. Region index = (addr−PROM_START)>>PROM_AW. No SDRAM write is issued.
- Any other address: the byte is ignored.
- addr == ENC_ADDR: `encrypted` ← data[0]. The byte is also routed normally.

SDRAM handshake uses a single pending slot:
- `prog_we` rises and stays high until `prog_ack` is sampled high.
- A new SDRAM-bound `ioctl_wr` while the slot is pending, with no `prog_ack` that same cycle, sets `dwn_err`. The new byte is dropped.
- `prog_ack` and a new write in the same cycle: the new write is accepted and `prog_we` stays high with the new address and data.
- `dwn_err` clears on the rising edge of `downloading`.

Reset FSM:
- States: WAIT_RDY, LOAD, HOLD, RUN. `game_rst`=1 in every state except RUN.
- Any state, rising edge of `downloading` → LOAD.
- LOAD → WAIT_RDY when `downloading`=0 and no write is pending.
- WAIT_RDY → HOLD when `rom_ready`=1. Entering HOLD loads the counter with RST_HOLD−1.
- HOLD → RUN when the counter reaches 0.
- HOLD or RUN → WAIT_RDY when `rom_ready`=0.
- Reset-state outputs: state WAIT_RDY, `game_rst`=1, `prog_we`=0, `prom_we`=0, `encrypted`=0, `dwn_err`=0, `checksum`=0. `prog_addr`, `prog_mask` and `prom_addr` reset to 0.
- `rst` asserted mid-download: the pending write is abandoned and `prog_we` drops asynchronously.

## Timing
- `ioctl_wr` sampled at cycle n: `prom_we`, `prom_addr` and `prom_data` are valid at cycle n+1, one cycle wide. `prog_we` rises at n+1.
- `prog_ack` high at cycle m: `prog_we` is low at m+1, unless a same-cycle write was accepted.
- `encrypted` updates at n+1.
- Release timing: `rom_ready` high at cycle k while in WAIT_RDY → `game_rst` low at cycle k+1+RST_HOLD.
- Back-to-back PROM writes are allowed on every cycle.

## Configuration
- Macro JTPOPEYE_CHKSUM_EN defined: `checksum` is the 16-bit wrap-around sum of every accepted byte, SDRAM and PROM alike. It clears on the rising edge of `downloading`. Dropped and ignored bytes are excluded.
- Macro undefined: `checksum` is tied to 0 and no adder is built.

## Structure
- Package jtpopeye_dwnld_pkg holds:
  - the FSM state enum;
  - default PROM_START and ENC_ADDR;
  - a `popeye_prom_e` index enum: 7J=0, 5B=1, 5A=2, 4A=3, 3A=4, 5N=5.
- One sub-module, jtpopeye_dwnld_rstseq, contains the reset FSM and hold counter.

## Test plan
- Byte at addr 0x0003, data 0xA5 → prog_addr 0x0001, prog_data 0xA5A5, prog_mask 2'b01, prog_we held until ack.
- Bytes to PROM_START+0x800+7 and PROM_START+5·0x800 on consecutive cycles → prom_we 6'b000010 at offset 7, then 6'b100000 at offset 0. prog_we is never asserted.
- ENC_ADDR written with 0x01 → encrypted=1 one cycle later. A second download writing 0x00 → encrypted=0.
- Second SDRAM write while prog_ack is held low → dwn_err=1 and the second byte is dropped. Then ack and a new write in the same cycle → write accepted, dwn_err still 1 until the next download.
- Download ends, rom_ready rises at cycle k with RST_HOLD=16 → game_rst falls at k+17. Dropping rom_ready in RUN reasserts game_rst the next cycle.
- With JTPOPEYE_CHKSUM_EN, bytes 0xFF×300 → checksum 0x2AD4 (300·255 mod 65536). `rst` asserted mid-download → all outputs at reset values.
